// File: rtl/q_measure_sequencer.sv
// Measurement sequencer: loads the DAC with the requested reference current, waits for settling,
// averages 2^LOG2_AVG ADC samples of Q and holds the result until the reference changes.
module q_measure_sequencer #(
    parameter int BUS_WIDTH     = 10,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOG2_AVG      = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 adc_valid,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 adc_timeout
);

    localparam int AW = BUS_WIDTH + LOG2_AVG;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = LOG2_AVG + 1;
    localparam int N  = 1 << LOG2_AVG;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        ACQ,
        DONE
    } state_t;

    state_t               state;
    logic [BUS_WIDTH-1:0] ref_q;
    logic [SW-1:0]        settle_cnt;
    logic [CW-1:0]        sample_cnt;
    logic [TW-1:0]        idle_cnt;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_next;
    logic                 ref_changed;

    always_comb begin
        acc_next    = acc + AW'(adc_data);
        ref_changed = (i_ref != ref_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            ref_q       <= '0;
            dac_code    <= '0;
            dac_load    <= 1'b0;
            q_measured  <= '0;
            ready       <= 1'b0;
            adc_timeout <= 1'b0;
            settle_cnt  <= '0;
            sample_cnt  <= '0;
            idle_cnt    <= '0;
            acc         <= '0;
        end else begin
            dac_load <= 1'b0;
            case (state)
                LOAD: begin
                    ref_q      <= i_ref;
                    dac_code   <= i_ref;
                    dac_load   <= 1'b1;
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (ref_changed) begin
                        ready <= 1'b0;
                        state <= LOAD;
                    end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        acc        <= '0;
                        sample_cnt <= '0;
                        idle_cnt   <= '0;
                        state      <= ACQ;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ACQ: begin
                    // Reference mismatch outranks sample acceptance and timeout on the same edge.
                    if (ref_changed) begin
                        ready <= 1'b0;
                        state <= LOAD;
                    end else if (adc_valid) begin
                        idle_cnt <= '0;
                        if (sample_cnt == CW'(N - 1)) begin
                            q_measured <= BUS_WIDTH'(acc_next >> LOG2_AVG);
                            ready      <= 1'b1;
                            state      <= DONE;
                        end else begin
                            acc        <= acc_next;
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        adc_timeout <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ref_changed) begin
                        ready <= 1'b0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
